// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format encodings and the
// instruction bit positions each RV32I immediate field is gathered from.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_H16 = 3'd5,
    FMT_Z5  = 3'd6,
    FMT_RSV = 3'd7
  } imm_fmt_e;

  localparam int INSTR_W  = 32;
  localparam int SIGN_BIT = 31;

  localparam int I_LSB    = 20;

  localparam int S_HI_LSB = 25;
  localparam int S_LO_MSB = 11;
  localparam int S_LO_LSB = 7;

  localparam int B_B11    = 7;
  localparam int B_HI_MSB = 30;
  localparam int B_HI_LSB = 25;
  localparam int B_LO_MSB = 11;
  localparam int B_LO_LSB = 8;

  localparam int U_LSB    = 12;

  localparam int J_HI_MSB = 19;
  localparam int J_HI_LSB = 12;
  localparam int J_B11    = 20;
  localparam int J_LO_MSB = 30;
  localparam int J_LO_LSB = 21;

  localparam int H16_MSB  = 15;

  localparam int Z5_MSB   = 19;
  localparam int Z5_LSB   = 15;

  // Zero-extension only has meaning for the formats that carry a plain field.
  function automatic logic zext_applies(input imm_fmt_e fmt);
    return (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_H16);
  endfunction

endpackage

// File: rtl/imm_field_ext.sv
// Combinational immediate extraction: gathers the format's field from the
// instruction word and extends it to XLEN (sign or zero).
module imm_field_ext
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  imm_fmt_e           fmt,
  input  logic               zext,
  output logic [XLEN-1:0]    imm,
  output logic               err
);

  logic               field_msb;
  logic               sgn;
  logic signed [31:0] raw;

  // Every format is first built as a 32-bit value whose bit 31 already holds
  // the extension bit, so widening to XLEN is a single signed cast.
  always_comb begin
    field_msb = (fmt == FMT_H16) ? instr[H16_MSB] : instr[SIGN_BIT];
    sgn       = field_msb & ~(zext & zext_applies(fmt));
    raw       = '0;
    err       = 1'b0;
    case (fmt)
      FMT_I:   raw = {{20{sgn}}, instr[SIGN_BIT:I_LSB]};
      FMT_S:   raw = {{20{sgn}}, instr[SIGN_BIT:S_HI_LSB], instr[S_LO_MSB:S_LO_LSB]};
      FMT_B:   raw = {{20{sgn}}, instr[B_B11], instr[B_HI_MSB:B_HI_LSB],
                      instr[B_LO_MSB:B_LO_LSB], 1'b0};
      FMT_U:   raw = {instr[SIGN_BIT:U_LSB], 12'b0};
      FMT_J:   raw = {{12{sgn}}, instr[J_HI_MSB:J_HI_LSB], instr[J_B11],
                      instr[J_LO_MSB:J_LO_LSB], 1'b0};
      FMT_H16: raw = {{16{sgn}}, instr[H16_MSB:0]};
      FMT_Z5:  raw = {27'b0, instr[Z5_MSB:Z5_LSB]};
      default: begin
        raw = '0;
        err = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: one output register plus a skid register so
// decode may stall without losing an accepted immediate; counts reserved formats.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_fmt,
  input  logic               in_zext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               err_clr
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  logic [XLEN-1:0]  imm_p0;
  logic             err_p0;

  logic             vld_p1;
  logic [XLEN-1:0]  imm_p1;
  logic             err_p1;
  logic             skid_vld_p1;
  logic [XLEN-1:0]  skid_imm_p1;
  logic             skid_err_p1;
  logic [CNT_W-1:0] cnt_q;

  logic in_fire;
  logic out_fire;
  logic adv;

  // ---- stage p0: field extraction and extension ----
  imm_field_ext #(
    .XLEN (XLEN)
  ) u_field_ext (
    .instr (in_instr),
    .fmt   (imm_fmt_e'(in_fmt)),
    .zext  (in_zext),
    .imm   (imm_p0),
    .err   (err_p0)
  );

  assign in_ready = ~skid_vld_p1;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p1 & out_ready;
  assign adv      = out_fire | ~vld_p1;

  // ---- stage p1: output register and skid register ----
  // The skid only fills while the output is stalled, and it drains into the
  // output register before any new input is accepted, which keeps FIFO order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      imm_p1      <= '0;
      err_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (adv) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        imm_p1      <= skid_imm_p1;
        err_p1      <= skid_err_p1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= in_fire;
        if (in_fire) begin
          imm_p1 <= imm_p0;
          err_p1 <= err_p0;
        end
      end
    end else if (in_fire) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && !adv) begin
      skid_imm_p1 <= imm_p0;
      skid_err_p1 <= err_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (in_fire && err_p0) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid = vld_p1;
  assign out_imm   = imm_p1;
  assign out_err   = err_p1;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: three instances (XLEN=32, XLEN=64,
// CNT_W=2) share one stimulus stream; expected values are hand-computed.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_fmt = '0;
  logic        in_zext = 1'b0;
  logic        out_ready = 1'b1;
  logic        err_clr = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_imm;
  logic [15:0] a_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [63:0] b_out_imm;
  logic [15:0] b_err_cnt;
  logic        c_in_ready, c_out_valid, c_out_err;
  logic [31:0] c_out_imm;
  logic [1:0]  c_err_cnt;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_zext(in_zext),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_err(a_out_err), .err_cnt(a_err_cnt), .err_clr(err_clr)
  );

  imm_extend_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_zext(in_zext),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_err(b_out_err), .err_cnt(b_err_cnt), .err_clr(err_clr)
  );

  imm_extend_pipe #(.XLEN(32), .CNT_W(2)) dutc2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_zext(in_zext),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm),
    .out_err(c_out_err), .err_cnt(c_err_cnt), .err_clr(err_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic        zext;
    logic [31:0] instr;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  logic [31:0] got_q[$];
  bit          collect = 1'b0;

  always @(negedge clk)
    if (collect && a_out_valid && out_ready) got_q.push_back(a_out_imm);

  initial begin
    vecs = '{
      '{3'd0, 1'b0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF},
      '{3'd1, 1'b0, 32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC},
      '{3'd2, 1'b0, 32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8},
      '{3'd3, 1'b0, 32'h123452B7, 32'h12345000, 64'h0000000012345000},
      '{3'd4, 1'b0, 32'h0080006F, 32'h00000008, 64'h0000000000000008},
      '{3'd4, 1'b0, 32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC},
      '{3'd5, 1'b0, 32'h00008000, 32'hFFFF8000, 64'hFFFFFFFFFFFF8000},
      '{3'd5, 1'b1, 32'h00008000, 32'h00008000, 64'h0000000000008000},
      '{3'd6, 1'b0, 32'h000F8000, 32'h0000001F, 64'h000000000000001F},
      '{3'd6, 1'b1, 32'h000F8000, 32'h0000001F, 64'h000000000000001F},
      '{3'd0, 1'b1, 32'hFFF00093, 32'h00000FFF, 64'h0000000000000FFF},
      '{3'd1, 1'b1, 32'hFE20AE23, 32'h00000FFC, 64'h0000000000000FFC},
      '{3'd2, 1'b1, 32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8},
      '{3'd3, 1'b0, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000},
      '{3'd0, 1'b0, 32'h7FF00093, 32'h000007FF, 64'h00000000000007FF},
      '{3'd3, 1'b1, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000},
      '{3'd4, 1'b1, 32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC},
      '{3'd6, 1'b0, 32'hFFFFFFFF, 32'h0000001F, 64'h000000000000001F},
      '{3'd5, 1'b0, 32'hFFFF7FFF, 32'h00007FFF, 64'h0000000000007FFF}
    };

    // Reset state
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_imm", a_out_imm, 0);
    check("rst_out_err", a_out_err, 0);
    check("rst_err_cnt", a_err_cnt, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick();
    check("rst_in_ready", a_in_ready, 1);
    check("rst_idle_valid", a_out_valid, 0);

    // Back-to-back formats, one result per cycle
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_fmt   = vecs[i].fmt;
      in_zext  = vecs[i].zext;
      in_instr = vecs[i].instr;
      tick();
      check($sformatf("fmt_vld_%0d", i), a_out_valid, 1);
      check($sformatf("fmt_imm32_%0d", i), a_out_imm, vecs[i].e32);
      check($sformatf("fmt_imm64_%0d", i), b_out_imm, vecs[i].e64);
      check($sformatf("fmt_err_%0d", i), a_out_err, 0);
    end
    in_valid = 1'b0;
    in_zext  = 1'b0;
    tick();
    check("drain_valid", a_out_valid, 0);
    tick();

    // Backpressure through the skid buffer
    collect  = 1'b1;
    in_valid = 1'b1;
    in_fmt   = 3'd0;
    in_instr = 32'h00100093;
    tick();
    check("bp_first_imm", a_out_imm, 1);
    check("bp_first_ready", a_in_ready, 1);
    out_ready = 1'b0;
    in_instr  = 32'h00200093;
    tick();
    check("bp_skid_full", a_in_ready, 0);
    check("bp_hold1", a_out_imm, 1);
    in_instr = 32'h00300093;
    tick();
    check("bp_still_full", c_in_ready, 0);
    check("bp_hold2", a_out_imm, 1);
    check("bp_hold2_vld", a_out_valid, 1);
    tick();
    check("bp_hold3", a_out_imm, 1);
    out_ready = 1'b1;
    tick();
    check("bp_out2", a_out_imm, 2);
    check("bp_ready_back", a_in_ready, 1);
    tick();
    check("bp_out3", a_out_imm, 3);
    in_instr = 32'h00400093;
    tick();
    check("bp_out4", a_out_imm, 4);
    in_valid = 1'b0;
    tick();
    check("bp_drained", a_out_valid, 0);
    collect = 1'b0;
    check("bp_count", got_q.size(), 4);
    for (int k = 0; k < got_q.size() && k < 4; k++)
      check($sformatf("bp_order_%0d", k), got_q[k], k + 1);

    // Reserved format: error flag, counter, saturation, clear priority
    in_valid = 1'b1;
    in_fmt   = 3'd7;
    in_instr = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rsv_err_%0d", k), a_out_err, 1);
      check($sformatf("rsv_imm_%0d", k), a_out_imm, 0);
    end
    in_valid = 1'b0;
    tick();
    check("rsv_cnt3", a_err_cnt, 3);
    check("rsv_cnt3_w2", c_err_cnt, 3);
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    tick();
    check("rsv_cnt5", a_err_cnt, 5);
    check("rsv_sat_w2", c_err_cnt, 3);
    in_valid = 1'b1;
    err_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    check("clr_prio", a_err_cnt, 0);
    check("clr_prio_w2", c_err_cnt, 0);
    tick();
    check("clr_stays", a_err_cnt, 0);

    // Reset while both registers are occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_fmt    = 3'd7;
    tick();
    in_fmt   = 3'd0;
    in_instr = 32'h00500093;
    tick();
    in_valid = 1'b0;
    check("stall_full", a_in_ready, 0);
    check("stall_cnt", a_err_cnt, 1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_cnt", a_err_cnt, 0);
    check("mid_rst_imm", a_out_imm, 0);
    check("mid_rst_err", a_out_err, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    check("post_rst_ready", a_in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("no_stale_%0d", k), a_out_valid, 0);
      tick();
    end
    in_valid = 1'b1;
    in_instr = 32'h00700093;
    tick();
    in_valid = 1'b0;
    check("post_rst_vld", a_out_valid, 1);
    check("post_rst_imm", a_out_imm, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate generator and extender for the RISC-V datapath.
- Replaces the fixed 16→32 sign extender.
- Decodes all RV32I immediate formats plus the legacy 16-bit field, and extends to XLEN with sign or zero mode.
- Sits between the fetch/decode register and the ALU operand mux; valid/ready handshake with a 2-entry skid buffer, so decode can stall without dropping immediates.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- CNT_W, 16, width of saturating illegal-format counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction.
- in_instr  input  32  raw instruction word.
- in_fmt  input  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 H16, 6 Z5, 7 reserved.
- in_zext  input  1  zero-extend instead of sign-extend; affects fmt 0, 1, 5 only.
- out_valid  output  1  out_imm valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_err  output  1  current output came from reserved fmt.
- err_cnt  output  CNT_W  count of reserved-fmt transfers accepted.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (reset=0, async): out_valid=0, out_imm=0, out_err=0, err_cnt=0, skid empty, in_ready=1 one cycle after reset deasserts (combinational from registered skid state).
- Field extraction (raw field, then extension to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}; sign-extended from bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - H16: instr[15:0] (legacy mode).
  - Z5: instr[19:15], always zero-extended.
  - fmt 7: imm=0, err=1.
- Extension: sign by replicating field MSB to XLEN; zero when in_zext=1 (fmt 0, 1, 5). in_zext is ignored for B, U, J, Z5.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Latency exactly 1 cycle from input transfer to out_valid with empty buffer.
  - Throughput 1 per cycle while out_ready=1.
  - Output held stable while out_valid & !out_ready.
- Skid buffer:
  - Main output register plus one skid register.
  - in_ready = !skid_valid.
  - If input transfers while output is stalled, data goes to skid.
  - On the next output transfer, skid moves to main and skid_valid clears.
  - Ordering is strictly FIFO.
  - Simultaneous in/out transfer with empty skid: main reloads directly.
  - Both full: in_ready=0; upstream data is not sampled.
- err_cnt:
  - Increments on each accepted input with fmt 7.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority over increment in the same cycle, giving 0.
- Reset mid-stall discards both buffered entries; nothing is replayed.
- in_instr/in_fmt are X-tolerant when in_valid=0; no state changes.

Decomposition:
- Shared package imm_pkg: format encodings (FMT_I … FMT_RSV) and field bit-position constants.
- One sub-module, imm_field_ext: purely combinational extraction and extension (instr, fmt, zext → imm, err), parametrised by XLEN.
- The top holds the handshake, skid buffer and counter.

Test Plan:
- Basic formats, XLEN=32, out_ready=1:
  - I 0xFFF00093 → 0xFFFFFFFF.
  - S 0xFE20AE23 → 0xFFFFFFFC.
  - B 0xFE000CE3 → 0xFFFFFFF8.
  - U 0x123452B7 → 0x12345000.
  - Each appears one cycle after acceptance.
- Legacy/zext: H16 instr 0x00008000 → 0xFFFF8000 with zext=0, 0x00008000 with zext=1; Z5 instr 0x000F8000 → 0x0000001F regardless of zext.
- XLEN=64: U 0x800000B7 → 0xFFFFFFFF80000000; I 0x7FF00093 → 0x00000000000007FF.
- Backpressure: stream 4 I-type immediates 1, 2, 3, 4 with out_ready low for 3 cycles after first output → in_ready drops after skid fills; outputs 1, 2, 3, 4 in order, none lost or duplicated.
- Errors: 3 fmt-7 transfers → out_err=1, out_imm=0 each, err_cnt=3; err_clr with simultaneous fmt 7 → err_cnt=0. With CNT_W=2, 5 errors → err_cnt=3.
- Reset mid-stall: fill main+skid, assert reset=0 asynchronously mid-cycle → out_valid=0 and err_cnt=0 immediately; after release in_ready=1 and no stale data emitted.
